er_guard_multi: RTL and testbench
=================================

// Module: er_guard_multi
// PURPOSE
//  Multi-region executable-range guard for VRASED/VERSA-style attestation.
//  - Monitors N executable regions (ERs).
//  - Forces the system reset when an interrupt or DMA occurs while the PC is inside an enabled ER.
//  - Also forces reset when a DMA address targets an enabled ER.
//  - Holds reset for a minimum pulse width, and records the cause and region of the violation.
//  - Sits beside the CPU core; `reset` feeds the PUC/reset tree.
// PARAMETERS
//  NUM_ER        4        number of monitored regions (1..16)
//  ADDR_W        16       PC and address width
//  IDX_W         2        width of viol_region; must equal clog2(NUM_ER), minimum 1
//  RESET_HANDLER 16'h0000 PC value that re-arms execution
//  RST_HOLD      4        minimum cycles reset stays high after a violation (1..255)
// PORTS
//  clk          in   1               system clock, all logic on posedge
//  rst_n        in   1               synchronous, active-low reset
//  pc           in   ADDR_W          current program counter
//  irq          in   1               interrupt taken this cycle
//  dma_en       in   1               DMA active this cycle
//  dma_addr     in   ADDR_W          DMA target address (qualified by dma_en)
//  er_min_flat  in   NUM_ER*ADDR_W   region i lower bound = [i*ADDR_W +: ADDR_W]
//  er_max_flat  in   NUM_ER*ADDR_W   region i upper bound, inclusive
//  er_valid     in   NUM_ER          per-region enable
//  reset        out  1               registered reset request to the core
//  viol_cause   out  2               00 none, 01 irq, 10 dma during ER, 11 dma into ER
//  viol_region  out  IDX_W           index of the region that caused the last violation
// BEHAVIOUR
//  - Region i is live when er_valid[i] && er_min<=er_max. A live region with min>max never matches.
//  - pc_hit[i]  = live[i] && min<=pc<=max.
//  - dma_hit[i] = live[i] && dma_en && min<=dma_addr<=max.
//  - viol = |pc_hit && (irq||dma_en) || |dma_hit.
//  - Cause priority: irq (01), then dma during ER (10), then dma into ER (11).
//  - Region recorded = lowest index that matched the winning cause.
//  - FSM states ABORT, ARMED, EXEC. Reset values:
//    state=ABORT, hold_cnt=RST_HOLD-1, reset=1, viol_cause=00, viol_region=0.
//  - EXEC:  viol -> ABORT; load hold_cnt=RST_HOLD-1; capture cause and region.
//           reset=1 from the next cycle.
//  - ABORT: reset=1.
//           viol -> reload hold_cnt and recapture cause and region; stay in ABORT.
//           else if hold_cnt==0 -> ARMED.
//           else decrement hold_cnt.
//  - ARMED: reset=1.
//           viol -> ABORT with reload and capture.
//           else if pc==RESET_HANDLER -> EXEC; reset=0 from the next cycle.
//  - Reset stays high for at least RST_HOLD+1 cycles after a violation.
//  - No combinational path from inputs to `reset`.
//  - viol_cause and viol_region stay stable until the next captured violation; EXEC entry does not clear them.
//  - Compare arithmetic is unsigned and full-width. Boundaries are inclusive at both min and max.
//  - Overlapping regions are legal.
//  - Region bounds may change at any time; they are sampled each cycle.
//  - rst_n low at any time, including mid-hold, restores the reset values on the next edge.
// CONFIGURATION
//  ER_GUARD_STICKY_LOG_EN
//  - Defined: adds ports `log_clr in 1` and `viol_log out NUM_ER`.
//    - viol_log[i] is set on any capture that names region i.
//    - All bits are cleared on log_clr or rst_n low.
//    - Set wins over log_clr in the same cycle.
//  - Undefined: neither port exists, and there is no extra logic.
// TESTING
//  T1 rst_n=0 for 2 cycles, then pc=0 -> reset=1 for RST_HOLD+1 cycles, then reset=0 one cycle after ARMED sees pc=0.
//  T2 EXEC, region0=[E000,E0FF], pc=E0FF, irq=1 -> reset=1 next cycle, viol_cause=01, viol_region=0.
//  T3 EXEC, pc=0x1000, dma_en=1, dma_addr=E000 -> viol_cause=11; same stimulus with er_valid[0]=0 -> no reset.
//  T4 ABORT hold_cnt=1, irq with pc in region2 -> hold reloaded, viol_region=2, reset held high RST_HOLD more cycles.
//  T5 pc=E100 (max+1) with irq and dma_en -> no violation; pc=DFFF likewise; region with min=F000, max=E000 never hits.
//  T6 With ER_GUARD_STICKY_LOG_EN: violations in regions 1 and 3 -> viol_log=4'b1010; log_clr -> 0000 next cycle.

Source files
------------

// File: rtl/er_guard_multi.sv
// rtl/er_guard_multi.sv - multi-region executable-range guard forcing core reset on IRQ/DMA violations
// Optional ER_GUARD_STICKY_LOG_EN adds log_clr/viol_log: a sticky per-region violation history.
module er_guard_multi #(
  parameter int                NUM_ER        = 4,
  parameter int                ADDR_W        = 16,
  parameter int                IDX_W         = 2,
  parameter logic [ADDR_W-1:0] RESET_HANDLER = '0,
  parameter int                RST_HOLD      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        pc,
  input  logic                     irq,
  input  logic                     dma_en,
  input  logic [ADDR_W-1:0]        dma_addr,
  input  logic [NUM_ER*ADDR_W-1:0] er_min_flat,
  input  logic [NUM_ER*ADDR_W-1:0] er_max_flat,
  input  logic [NUM_ER-1:0]        er_valid,
  output logic                     reset,
  output logic [1:0]               viol_cause,
  output logic [IDX_W-1:0]         viol_region
`ifdef ER_GUARD_STICKY_LOG_EN
  ,
  input  logic                     log_clr,
  output logic [NUM_ER-1:0]        viol_log
`endif
);

  typedef enum logic [1:0] {ABORT, ARMED, EXEC} state_t;

  localparam logic [7:0] HOLD_INIT = 8'(RST_HOLD - 1);

  state_t           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             reset_q, reset_d;
  logic [1:0]       cause_q, cause_d;
  logic [IDX_W-1:0] region_q, region_d;

  logic [NUM_ER-1:0] pc_hit, dma_hit;
  logic [IDX_W-1:0]  pc_idx, dma_idx, region_c;
  logic [1:0]        cause_c;
  logic              viol, capture;

  always_comb begin
    pc_hit  = '0;
    dma_hit = '0;
    for (int i = 0; i < NUM_ER; i++) begin
      logic [ADDR_W-1:0] lo, hi;
      lo = er_min_flat[i*ADDR_W +: ADDR_W];
      hi = er_max_flat[i*ADDR_W +: ADDR_W];
      if (er_valid[i] && (lo <= hi)) begin
        pc_hit[i]  = (pc >= lo) && (pc <= hi);
        dma_hit[i] = dma_en && (dma_addr >= lo) && (dma_addr <= hi);
      end
    end
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    pc_idx  = '0;
    dma_idx = '0;
    for (int i = NUM_ER - 1; i >= 0; i--) begin
      if (pc_hit[i])  pc_idx  = IDX_W'(i);
      if (dma_hit[i]) dma_idx = IDX_W'(i);
    end
  end

  always_comb begin
    cause_c  = 2'b00;
    region_c = '0;
    viol     = ((|pc_hit) && (irq || dma_en)) || (|dma_hit);
    if ((|pc_hit) && irq) begin
      cause_c  = 2'b01;
      region_c = pc_idx;
    end else if ((|pc_hit) && dma_en) begin
      cause_c  = 2'b10;
      region_c = pc_idx;
    end else if (|dma_hit) begin
      cause_c  = 2'b11;
      region_c = dma_idx;
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    cause_d  = cause_q;
    region_d = region_q;
    capture  = 1'b0;
    case (state_q)
      EXEC:    capture = viol;
      ABORT: begin
        if (viol)              capture = 1'b1;
        else if (hold_q == '0) state_d = ARMED;
        else                   hold_d  = hold_q - 8'd1;
      end
      ARMED: begin
        if (viol)                     capture = 1'b1;
        else if (pc == RESET_HANDLER) state_d = EXEC;
      end
      default: state_d = ABORT;
    endcase
    if (capture) begin
      state_d  = ABORT;
      hold_d   = HOLD_INIT;
      cause_d  = cause_c;
      region_d = region_c;
    end
    reset_d = (state_d != EXEC);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ABORT;
      hold_q   <= HOLD_INIT;
      reset_q  <= 1'b1;
      cause_q  <= 2'b00;
      region_q <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      reset_q  <= reset_d;
      cause_q  <= cause_d;
      region_q <= region_d;
    end
  end

  assign reset       = reset_q;
  assign viol_cause  = cause_q;
  assign viol_region = region_q;

`ifdef ER_GUARD_STICKY_LOG_EN
  logic [NUM_ER-1:0] log_q, log_d;

  // A capture in the same cycle as log_clr still leaves its bit set.
  always_comb begin
    log_d = log_q;
    if (log_clr) log_d = '0;
    if (capture) log_d[region_c] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) log_q <= '0;
    else        log_q <= log_d;
  end

  assign viol_log = log_q;
`endif

endmodule

// File: tb/tb_er_guard_multi.sv
// tb/tb_er_guard_multi.sv - directed bench for er_guard_multi with a cycle-level reference model
// Honours ER_GUARD_STICKY_LOG_EN when the design is built with it.
module tb_er_guard_multi;
  localparam int          NUM_ER   = 4;
  localparam int          ADDR_W   = 16;
  localparam int          IDX_W    = 2;
  localparam int          RST_HOLD = 4;
  localparam logic [15:0] RH       = 16'h0000;

  logic                     clk = 1'b0;
  logic                     rst_n, irq, dma_en;
  logic [ADDR_W-1:0]        pc, dma_addr;
  logic [NUM_ER*ADDR_W-1:0] er_min_flat, er_max_flat;
  logic [NUM_ER-1:0]        er_valid;
  logic                     reset;
  logic [1:0]               viol_cause;
  logic [IDX_W-1:0]         viol_region;
`ifdef ER_GUARD_STICKY_LOG_EN
  logic                     log_clr;
  logic [NUM_ER-1:0]        viol_log;
`endif

  er_guard_multi #(
    .NUM_ER(NUM_ER), .ADDR_W(ADDR_W), .IDX_W(IDX_W),
    .RESET_HANDLER(RH), .RST_HOLD(RST_HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .irq(irq), .dma_en(dma_en),
    .dma_addr(dma_addr), .er_min_flat(er_min_flat), .er_max_flat(er_max_flat),
    .er_valid(er_valid), .reset(reset), .viol_cause(viol_cause),
    .viol_region(viol_region)
`ifdef ER_GUARD_STICKY_LOG_EN
    , .log_clr(log_clr), .viol_log(viol_log)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: the core runs once RESET_HANDLER is seen at least RST_HOLD cycles after the last violation.
  bit         m_run    = 1'b0;
  int         m_since  = 0;
  logic [1:0] m_cause  = 2'b00;
  int         m_region = 0;
  logic       mv;
  logic [1:0] mc;
  int         mr;
  bit         chk_en   = 1'b0;

  function automatic void model_eval(output logic v, output logic [1:0] c, output int r);
    int fp, fd;
    logic [ADDR_W-1:0] lo, hi;
    fp = -1;
    fd = -1;
    for (int i = 0; i < NUM_ER; i++) begin
      lo = er_min_flat[i*ADDR_W +: ADDR_W];
      hi = er_max_flat[i*ADDR_W +: ADDR_W];
      if (er_valid[i] && lo <= hi) begin
        if (fp < 0 && pc >= lo && pc <= hi) fp = i;
        if (fd < 0 && dma_en && dma_addr >= lo && dma_addr <= hi) fd = i;
      end
    end
    v = 1'b1;
    c = 2'b00;
    r = 0;
    if (fp >= 0 && irq)         begin c = 2'b01; r = fp; end
    else if (fp >= 0 && dma_en) begin c = 2'b10; r = fp; end
    else if (fd >= 0)           begin c = 2'b11; r = fd; end
    else v = 1'b0;
  endfunction

  always @(posedge clk) begin
    model_eval(mv, mc, mr);
    if (!rst_n) begin
      m_run = 1'b0; m_since = 0; m_cause = 2'b00; m_region = 0;
    end else if (mv) begin
      m_run = 1'b0; m_since = 0; m_cause = mc; m_region = mr;
    end else if (!m_run) begin
      if (m_since >= RST_HOLD && pc == RH) m_run = 1'b1;
      else m_since++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_reset",  32'(reset),       32'(!m_run));
      check("cyc_cause",  32'(viol_cause),  32'(m_cause));
      check("cyc_region", 32'(viol_region), 32'(m_region));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_region(input int i, input logic [15:0] lo, input logic [15:0] hi);
    er_min_flat[i*ADDR_W +: ADDR_W] = lo;
    er_max_flat[i*ADDR_W +: ADDR_W] = hi;
  endtask

  task automatic recover(input string name);
    pc = RH; irq = 1'b0; dma_en = 1'b0;
    repeat (6) step();
    check(name, 32'(reset), 0);
  endtask

  initial begin
    rst_n = 1'b0; irq = 1'b0; dma_en = 1'b0; pc = 16'h1234; dma_addr = '0;
    er_min_flat = '0; er_max_flat = '0; er_valid = 4'b1111;
`ifdef ER_GUARD_STICKY_LOG_EN
    log_clr = 1'b0;
`endif
    set_region(0, 16'hE000, 16'hE0FF);
    set_region(1, 16'hC000, 16'hC0FF);
    set_region(2, 16'hA000, 16'hA0FF);
    set_region(3, 16'hF000, 16'hE000);

    // T1: reset values, then hold and release on RESET_HANDLER
    step(); step();
    chk_en = 1'b1;
    check("rst_reset",  32'(reset), 1);
    check("rst_cause",  32'(viol_cause), 0);
    check("rst_region", 32'(viol_region), 0);
    rst_n = 1'b1; pc = RH;
    repeat (4) begin step(); check("t1_hold", 32'(reset), 1); end
    step(); check("t1_release", 32'(reset), 0);

    // T2: irq at region 0 max
    pc = 16'hE0FF; irq = 1'b1; step();
    check("t2_reset", 32'(reset), 1);
    check("t2_cause", 32'(viol_cause), 1);
    check("t2_region", 32'(viol_region), 0);
    recover("t2_recover");

    // T3: dma into ER, then with the region disabled
    pc = 16'h1000; dma_en = 1'b1; dma_addr = 16'hE000; step();
    check("t3_cause", 32'(viol_cause), 3);
    check("t3_reset", 32'(reset), 1);
    recover("t3_recover");
    er_valid = 4'b1110;
    pc = 16'h1000; dma_en = 1'b1; dma_addr = 16'hE000; step();
    check("t3_disabled_reset", 32'(reset), 0);
    check("t3_sticky_cause", 32'(viol_cause), 3);
    dma_en = 1'b0; er_valid = 4'b1111;

    // dma during ER, and irq winning over a dma hit in another region
    pc = 16'hE010; dma_en = 1'b1; dma_addr = 16'h2000; step();
    check("dma_during_cause", 32'(viol_cause), 2);
    recover("dma_during_recover");
    pc = 16'hA010; irq = 1'b1; dma_en = 1'b1; dma_addr = 16'hC010; step();
    check("prio_cause", 32'(viol_cause), 1);
    check("prio_region", 32'(viol_region), 2);
    recover("prio_recover");
    set_region(1, 16'hA000, 16'hA0FF);
    pc = 16'hA050; irq = 1'b1; step();
    check("overlap_region", 32'(viol_region), 1);
    set_region(1, 16'hC000, 16'hC0FF);
    recover("overlap_recover");

    // T4: violation at region 0 min, then re-violation with hold_cnt=1
    pc = 16'hE000; irq = 1'b1; step();
    check("t4_min_region", 32'(viol_region), 0);
    irq = 1'b0; pc = RH; step(); step();
    pc = 16'hA010; irq = 1'b1; step();
    check("t4_region", 32'(viol_region), 2);
    irq = 1'b0; pc = RH;
    repeat (4) begin step(); check("t4_hold", 32'(reset), 1); end
    step(); check("t4_release", 32'(reset), 0);

    // T5: just outside bounds and an inverted region
    pc = 16'hE100; irq = 1'b1; dma_en = 1'b1; dma_addr = 16'h1000; step();
    check("t5_max_plus1", 32'(reset), 0);
    pc = 16'hDFFF; step();
    check("t5_min_minus1", 32'(reset), 0);
    pc = 16'hF800; dma_addr = 16'hE800; step();
    check("t5_inverted", 32'(reset), 0);
    irq = 1'b0; dma_en = 1'b0;
    check("t5_cause_kept", 32'(viol_cause), 1);

`ifdef ER_GUARD_STICKY_LOG_EN
    // T6: sticky log across regions 1 and 3, then clear
    set_region(3, 16'h8000, 16'h80FF);
    log_clr = 1'b1; step(); log_clr = 1'b0;
    check("t6_cleared", 32'(viol_log), 0);
    pc = 16'hC010; irq = 1'b1; step();
    recover("t6_recover1");
    pc = 16'h1000; dma_en = 1'b1; dma_addr = 16'h8010; step();
    dma_en = 1'b0;
    check("t6_log", 32'(viol_log), 32'hA);
    log_clr = 1'b1; step(); log_clr = 1'b0;
    check("t6_log_clr", 32'(viol_log), 0);
    recover("t6_recover2");
`endif

    // rst_n mid-hold restores reset values
    pc = 16'hE010; irq = 1'b1; step();
    irq = 1'b0; pc = 16'h1000; step();
    rst_n = 1'b0; step();
    check("midhold_cause", 32'(viol_cause), 0);
    check("midhold_reset", 32'(reset), 1);
    rst_n = 1'b1; step();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
